// File: rtl/msg_sched_stream.sv
// Streaming SHA-2 message schedule: 16 words in, W[0..NUM_ROUNDS-1] out via one registered slot.
// One cycle from input handshake to out_valid; a stalled slot holds its word and drops in_ready.
module msg_sched_stream #(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [6:0]        out_round,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, EXPAND = 2'b10, DRAIN = 2'b11} state_t;

  localparam logic [6:0] LAST_T = 7'(NUM_ROUNDS - 1);

  state_t            state, state_nxt;
  logic [6:0]        t;
  logic [3:0]        t4;
  logic [WORD_W-1:0] win [16];
  logic              free, in_hs, exp_step;
  logic [WORD_W-1:0] w_new;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign t4       = t[3:0];
  assign free     = !out_valid || out_ready;
  assign in_ready = (state == LOAD) && free;
  assign in_hs    = in_valid && in_ready;
  assign exp_step = (state == EXPAND) && free;
  assign busy     = (state != IDLE);
  assign o_state  = state;

  // Window offsets -2, -7, -15, -16 expressed as 4-bit wrap-around adds; slot t4 still holds W[t-16].
  assign w_new = sig1(win[t4 + 4'd14]) + win[t4 + 4'd9] + sig0(win[t4 + 4'd1]) + win[t4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_in) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_in) state_nxt = LOAD;
        LOAD:    if (in_hs && t == 7'd15) state_nxt = EXPAND;
        EXPAND:  if (exp_step && t == LAST_T) state_nxt = DRAIN;
        DRAIN:   if (out_valid && out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (abort_in) begin
      t         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start_in) t <= '0;
        LOAD: begin
          if (in_hs) begin
            win[t4]   <= in_data;
            out_data  <= in_data;
            out_round <= t;
            out_valid <= 1'b1;
            t         <= t + 7'd1;
          end else if (free) begin
            out_valid <= 1'b0;
          end
        end
        EXPAND: begin
          if (exp_step) begin
            win[t4]   <= w_new;
            out_data  <= w_new;
            out_round <= t;
            out_valid <= 1'b1;
            out_last  <= (t == LAST_T);
            t         <= t + 7'd1;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_sched_stream.sv
// Directed bench for msg_sched_stream: a SHA-256 and a SHA-512 instance share stimulus, sel picks one.
module tb_msg_sched_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_in, abort_in, in_valid, out_ready, sel;
  logic [63:0] in_data;

  logic        in_ready32, out_valid32, out_last32, busy32;
  logic [31:0] out_data32;
  logic [6:0]  out_round32;
  logic [1:0]  o_state32;
  logic        in_ready64, out_valid64, out_last64, busy64;
  logic [63:0] out_data64;
  logic [6:0]  out_round64;
  logic [1:0]  o_state64;

  logic        ir, ov, ol, bz;
  logic [63:0] od;
  logic [6:0]  orr;
  logic [1:0]  os;

  int          checks = 0;
  int          errors = 0;
  int          nrounds;
  logic [63:0] blk  [16];
  logic [63:0] gold [128];
  logic [63:0] cap  [128];

  msg_sched_stream #(.WORD_W(32), .NUM_ROUNDS(64)) u32 (
    .clk(clk), .rst_n(rst_n), .start_in(start_in && !sel), .abort_in(abort_in),
    .in_valid(in_valid && !sel), .in_ready(in_ready32), .in_data(in_data[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .out_round(out_round32), .out_last(out_last32), .busy(busy32), .o_state(o_state32)
  );

  msg_sched_stream #(.WORD_W(64), .NUM_ROUNDS(80)) u64 (
    .clk(clk), .rst_n(rst_n), .start_in(start_in && sel), .abort_in(abort_in),
    .in_valid(in_valid && sel), .in_ready(in_ready64), .in_data(in_data),
    .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
    .out_round(out_round64), .out_last(out_last64), .busy(busy64), .o_state(o_state64)
  );

  assign ir  = sel ? in_ready64  : in_ready32;
  assign ov  = sel ? out_valid64 : out_valid32;
  assign ol  = sel ? out_last64  : out_last32;
  assign bz  = sel ? busy64      : busy32;
  assign od  = sel ? out_data64  : {32'h0, out_data32};
  assign orr = sel ? out_round64 : out_round32;
  assign os  = sel ? o_state64   : o_state32;

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference SHA-2 schedule computed straight from the FIPS 180-4 recurrence.
  task automatic build_gold();
    logic [31:0] a, b, c, d;
    for (int i = 0; i < 16; i++) gold[i] = sel ? blk[i] : {32'h0, blk[i][31:0]};
    for (int i = 16; i < nrounds; i++) begin
      if (sel) begin
        gold[i] = (r64(gold[i-2], 19) ^ r64(gold[i-2], 61) ^ (gold[i-2] >> 6)) + gold[i-7]
                + (r64(gold[i-15], 1) ^ r64(gold[i-15], 8) ^ (gold[i-15] >> 7)) + gold[i-16];
      end else begin
        a = gold[i-2][31:0];
        b = gold[i-15][31:0];
        c = gold[i-7][31:0];
        d = gold[i-16][31:0];
        gold[i] = {32'h0, (r32(a, 17) ^ r32(a, 19) ^ (a >> 10)) + c
                        + (r32(b, 7) ^ r32(b, 18) ^ (b >> 3)) + d};
      end
    end
  endtask

  task automatic run_block(input bit stall, input bit gap, input int abort_at,
                           input int rst_at, input int start_at, input string tag);
    int           in_idx, exp_idx, first_cyc, last_cyc, want;
    bit           hold, stop;
    logic [71:0]  held;
    in_idx = 0; exp_idx = 0; first_cyc = 0; last_cyc = 0; hold = 0; stop = 0; held = '0;
    build_gold();
    @(negedge clk);
    start_in = 1'b1;
    #1 chk({tag, "_in_ready_at_start"}, ir, 0);
    @(negedge clk);
    start_in = 1'b0;
    #1 chk({tag, "_state_load"}, {bz, os}, 3'b101);
    for (int cyc = 0; cyc < 3000 && !stop; cyc++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (in_idx < 16) && !(gap && $urandom_range(0, 2) == 0);
      in_data   = blk[in_idx[3:0]];
      start_in  = (exp_idx == start_at);
      abort_in  = (abort_at >= 0) && ov && (orr == 7'(abort_at));
      #1;
      if (cyc == 0) chk({tag, "_in_ready_first"}, ir, 1);
      if (hold) chk({tag, "_hold_stable"}, {ov, od, orr, ol}, {1'b1, held});
      if (ov && !out_ready) chk({tag, "_in_ready_stalled"}, ir, 0);
      if (rst_at >= 0 && ov && orr == 7'(rst_at)) begin
        rst_n = 1'b0;
        #1 chk({tag, "_async_reset"}, {ov, od, orr, ol, ir, bz, os}, 0);
        stop = 1;
      end else begin
        if (in_valid && ir) in_idx++;
        if (ov && out_ready) begin
          chk({tag, "_word"}, {od, orr, ol},
              {gold[exp_idx], 7'(exp_idx), 1'(exp_idx == nrounds - 1)});
          cap[exp_idx] = od;
          if (exp_idx == 0) first_cyc = cyc;
          last_cyc = cyc;
          exp_idx++;
          if (abort_in) stop = 1;
        end
        hold = ov && !out_ready;
        held = {od, orr, ol};
        if (exp_idx == nrounds) stop = 1;
      end
      @(negedge clk);
    end
    start_in = 1'b0;
    abort_in = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    want = (abort_at >= 0) ? abort_at + 1 : (rst_at >= 0) ? rst_at : nrounds;
    chk({tag, "_word_count"}, exp_idx, want);
    chk({tag, "_idle_after"}, {bz, ov, os, ol}, 0);
    if (!stall && !gap && abort_at < 0 && rst_at < 0)
      chk({tag, "_span_cycles"}, last_cyc - first_cyc + 1, nrounds);
  endtask

  initial begin
    rst_n = 1'b0; start_in = 1'b0; abort_in = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0; sel = 1'b0; nrounds = 64;
    #1 chk("reset_outputs", {ov, od, orr, ol, ir, bz, os}, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 64'h61626380;
    blk[15] = 64'h18;
    run_block(0, 0, -1, -1, -1, "abc");
    chk("abc_w16", cap[16], 64'h61626380);
    chk("abc_w17", cap[17], 64'h000F0000);
    run_block(1, 0, -1, -1, -1, "abc_stall");
    run_block(0, 0, 30, -1, -1, "abort30");
    run_block(0, 0, -1, -1, 20, "start_in_expand");

    @(negedge clk);
    start_in = 1'b1;
    abort_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    abort_in = 1'b0;
    #1 chk("start_abort_idle", {bz, os}, 0);
    @(negedge clk);
    #1 chk("start_abort_idle_later", {bz, os, ir}, 0);

    run_block(0, 1, -1, 40, -1, "reset40");
    run_block(0, 1, -1, -1, -1, "abc_gaps");

    sel = 1'b1;
    nrounds = 80;
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 64'h1;
    run_block(0, 0, -1, -1, -1, "sha512");
    chk("sha512_w16", cap[16], 64'h0000000000000001);
    chk("sha512_w17", cap[17], 64'h0);
    chk("sha512_w18", cap[18], 64'h0000200000000008);
    run_block(1, 1, -1, -1, -1, "sha512_stall_gaps");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_sched_stream.md
Name: msg_sched_stream

Overview:
Parametrised, streaming SHA-2 message-schedule generator. It is the successor to the fixed 32-bit, 64-entry message-expansion block and sits between the padding/block-loader and the compression round core. It accepts the 16 block words over a valid/ready input and emits W[0..NUM_ROUNDS-1] over a valid/ready output with backpressure. It uses a 16-entry circular window in place of a full 64-entry array, and supports SHA-256 (32-bit) and SHA-512 (64-bit) word sizes.

Parameters:
WORD_W, 32, word width; legal values are 32 (SHA-224/256) and 64 (SHA-384/512).
NUM_ROUNDS, 64, number of schedule words emitted; 64 for WORD_W=32, 80 for WORD_W=64; must be in 17..127.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_in  in  1  one-cycle start of a new block; sampled only in IDLE.
abort_in  in  1  synchronous abort; returns the block to IDLE from any state.
in_valid  in  1  in_data is valid.
in_ready  out  1  block accepts in_data this cycle.
in_data  in  WORD_W  message word W[t], t=0..15, in order.
out_valid  out  1  out_data, out_round and out_last are valid.
out_ready  in  1  consumer accepts the output this cycle.
out_data  out  WORD_W  schedule word W[out_round].
out_round  out  7  index t of out_data.
out_last  out  1  high with the word t = NUM_ROUNDS-1.
busy  out  1  high when state is not IDLE.
o_state  out  2  current FSM state encoding.

Behaviour:
- Reset:
  - state = IDLE; t = 0; window cleared.
  - out_valid, out_data, out_round, out_last, in_ready all 0.
  - busy = 0; o_state = 0.
- State encodings: IDLE=00, LOAD=01, EXPAND=10, DRAIN=11.
- Output slot: one registered slot.
  - free = !out_valid || out_ready.
  - A handshake is out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_round and out_last are held stable.
- IDLE:
  - in_ready = 0.
  - If start_in && !abort_in: t <= 0, go to LOAD.
- LOAD:
  - in_ready = free.
  - On an input handshake: window[t mod 16] <= in_data; out_data <= in_data; out_round <= t; out_valid <= 1; t <= t+1.
  - After accepting t=15, go to EXPAND.
  - If free && !in_valid, out_valid <= 0.
- EXPAND:
  - in_ready = 0.
  - When free, in the same cycle:
    - W[t] = σ1(win[t-2]) + win[t-7] + σ0(win[t-15]) + win[t-16], modulo 2^WORD_W (carries dropped). All window indices are mod 16.
    - Write W[t] into win[t mod 16], overwriting W[t-16] after it has been read.
    - Load W[t] into the output slot; t <= t+1.
  - The word with t = NUM_ROUNDS-1 also sets out_last = 1, and the FSM goes to DRAIN.
- DRAIN:
  - in_ready = 0.
  - On the final output handshake: out_valid <= 0, out_last <= 0, go to IDLE.
- σ definitions:
  - WORD_W=32: σ0 = ROTR7 ^ ROTR18 ^ SHR3; σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - WORD_W=64: σ0 = ROTR1 ^ ROTR8 ^ SHR7; σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- Latency:
  - An input handshake in cycle n gives out_valid in cycle n+1.
  - start_in in cycle 0 gives in_ready earliest in cycle 1.
  - With in_valid=out_ready=1 continuously, one word per cycle and no bubbles. The first W[0] to W[NUM_ROUNDS-1] span is NUM_ROUNDS cycles.
- Boundaries:
  - Gaps in in_valid during LOAD insert output bubbles only; ordering is preserved.
  - start_in outside IDLE is ignored.
  - start_in and abort_in in the same IDLE cycle: abort wins; stay in IDLE.
  - abort_in in any state: next cycle state = IDLE, out_valid = 0, out_last = 0, t = 0. Window contents are don't-care.
  - A handshake coinciding with abort_in is still consumed by the consumer, but no further words are produced.
  - Asynchronous reset mid-block gives reset values immediately. No partial output after reset.
  - out_round never exceeds NUM_ROUNDS-1.

Test Plan:
- SHA-256 "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> 64 consecutive words; W16=0x61626380, W17=0x000F0000; all W match the golden model; out_last only at out_round=63.
- Same block with out_ready random 50% -> identical W sequence; out_data stable whenever out_valid && !out_ready; no drops or duplicates; in_ready=0 while the slot is stalled.
- WORD_W=64, NUM_ROUNDS=80; W0=1, others 0 -> W16=0x0000000000000001, W17=0; all 80 words match the golden model; out_last at round 79.
- abort_in asserted at out_round=30 in EXPAND -> next cycle busy=0, out_valid=0, o_state=00; a following start and "abc" block reproduces the correct schedule.
- start_in pulsed during EXPAND, and start_in+abort_in together in IDLE -> both ignored (schedule uninterrupted; stays in IDLE).
- rst_n dropped at round 40, then released -> all outputs 0 immediately; next block correct; in_valid gaps during LOAD -> bubbles only, W order intact.
